serial_add_sub: RTL and testbench
=================================

SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 1..32.
REQ-002 Port: clk  input  1  rising-edge clock; the only clock.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin an operation; sampled on the rising edge of clk.
REQ-005 Port: a  input  WIDTH  operand A.
REQ-006 Port: b  input  WIDTH  operand B.
REQ-007 Port: cin  input  1  carry-in; used in add mode only.
REQ-008 Port: sub  input  1  mode select: 0 = A+B+cin, 1 = A-B.
REQ-009 Port: busy  output  1  high while bits are being processed.
REQ-010 Port: done  output  1  one-cycle completion pulse.
REQ-011 Port: sum  output  WIDTH  registered result.
REQ-012 Port: carry  output  1  carry-out of the MSB; in sub mode 1 = no borrow.
REQ-013 Port: overflow  output  1  two's-complement signed overflow.

Function
REQ-014 The block SHALL use a single 1-bit full-adder datapath with a carry flip-flop, processing one bit per cycle, LSB first.
REQ-015 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-016 In IDLE, start=1 SHALL latch a, the effective B operand (b in add mode, ~b in sub mode) and the initial carry (cin in add mode, 1 in sub mode), clear the bit counter and enter SHIFT.
REQ-017 SHIFT SHALL last exactly WIDTH cycles; each cycle it SHALL compute one sum bit and update the carry flip-flop.
REQ-018 After the last bit, the FSM SHALL enter DONE; sum, carry and overflow SHALL be registered on that same edge.
REQ-019 DONE SHALL last one cycle, with done=1, and then SHALL return to IDLE.
REQ-020 done SHALL rise exactly WIDTH rising edges after the edge that sampled start.
REQ-021 busy SHALL be 1 only in SHIFT; it SHALL be 0 in IDLE and in DONE.
REQ-022 start SHALL be ignored in SHIFT and DONE; a, b, cin and sub SHALL be ignored except on the accepting edge.
REQ-023 Changes on a, b, cin or sub during SHIFT SHALL NOT affect the result.
REQ-024 sum, carry and overflow SHALL hold their values from the end of DONE until the next completion, and SHALL NOT change during SHIFT.
REQ-025 carry SHALL equal the carry-out of bit WIDTH-1.
REQ-026 overflow SHALL equal the carry into bit WIDTH-1 XOR the carry-out of bit WIDTH-1.
REQ-027 The result SHALL equal (A + B_eff + c0) mod 2^WIDTH, where B_eff is the effective B operand and c0 the initial carry.
REQ-028 For WIDTH=1, the block SHALL reduce to a one-bit add/subtract with a SHIFT phase of one cycle.
REQ-029 start held high continuously SHALL start a new operation on the first IDLE cycle after DONE, giving back-to-back operations with period WIDTH+2 cycles.

Reset
REQ-030 rst=1 SHALL, asynchronously, force IDLE and clear the counter, the carry flip-flop and the operand registers.
REQ-031 rst=1 SHALL, asynchronously, force busy=0, done=0, sum=0, carry=0 and overflow=0.
REQ-032 rst asserted mid-SHIFT SHALL abort the operation; no done pulse SHALL follow.
REQ-033 After rst deasserts, the next start SHALL behave as the first operation after power-up.

Verification
REQ-034 WIDTH=8, add: a=0xFF, b=0x01, cin=0 -> sum=0x00, carry=1, overflow=0, done 8 edges after start.
REQ-035 WIDTH=8, add: a=0x7F, b=0x01, cin=0 -> sum=0x80, carry=0, overflow=1; and a=0x0F, b=0x01, cin=1 -> sum=0x11, carry=0, overflow=0.
REQ-036 WIDTH=8, sub: a=0x05, b=0x07 -> sum=0xFE, carry=0, overflow=0; and a=0x80, b=0x01 -> sum=0x7F, carry=1, overflow=1.
REQ-037 WIDTH=1: all 8 combinations of a, b, cin in add mode -> {carry,sum} matches the full-adder truth table; each done arrives 1 edge after start.
REQ-038 Robustness: pulse start again mid-SHIFT with different operands -> the first result is unchanged and only one done pulse occurs; assert rst at SHIFT cycle 3 -> all outputs 0 immediately, no done, and the next operation is correct.
REQ-039 Random: at least 1000 operations at WIDTH=8 and WIDTH=32 with random sub/cin and start held high -> all results match the reference model, with done period WIDTH+2.

Source files
------------

// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial adder/subtractor.
// A single full-adder cell and a carry flip-flop process one bit per clock,
// LSB first. A+B+cin in add mode, A+~B+1 (A-B) in subtract mode.
// Result, carry-out and signed overflow are registered when the last bit
// completes and are held until the next operation finishes.
module serial_add_sub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow
);

   // Bit counter only needs to reach WIDTH-1; keep at least one bit.
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [WIDTH-1:0] a_q,     a_d;      // operand A, shifted right each bit
   logic [WIDTH-1:0] b_q,     b_d;      // effective operand B, shifted right
   logic [WIDTH-1:0] acc_q,   acc_d;    // result bits collected MSB-side
   logic             c_q,     c_d;      // running carry between bit slices
   logic [WIDTH-1:0] sum_q,   sum_d;
   logic             carry_q, carry_d;
   logic             ovf_q,   ovf_d;

   logic             bit_s;
   logic             bit_co;
   logic             last_bit;

   function automatic logic fa_sum(input logic x, input logic y, input logic c);
      return x ^ y ^ c;
   endfunction

   function automatic logic fa_carry(input logic x, input logic y, input logic c);
      return (x & y) | (x & c) | (y & c);
   endfunction

   // Single full-adder cell operating on the current LSBs.
   always_comb begin
      bit_s    = fa_sum(a_q[0], b_q[0], c_q);
      bit_co   = fa_carry(a_q[0], b_q[0], c_q);
      last_bit = (cnt_q == LAST_BIT);
   end

   // Next-state, datapath update and result capture.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      c_d     = c_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               // Subtraction is A + ~B + 1: invert B and seed the carry.
               a_d     = a;
               b_d     = sub ? ~b : b;
               c_d     = sub ? 1'b1 : cin;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            a_d            = a_q >> 1;
            b_d            = b_q >> 1;
            c_d            = bit_co;
            acc_d          = acc_q >> 1;
            acc_d[WIDTH-1] = bit_s;
            cnt_d          = cnt_q + CNT_W'(1);
            if (last_bit) begin
               // c_q is the carry into the MSB, bit_co the carry out of it.
               sum_d   = acc_d;
               carry_d = bit_co;
               ovf_d   = c_q ^ bit_co;
               cnt_d   = '0;
               state_d = DONE;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, datapath and result registers; reset clears everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         c_q     <= 1'b0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         c_q     <= c_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
      end
   end

   // Status flags decode straight from the state register so that reset
   // drops them immediately.
   always_comb begin
      busy     = (state_q == SHIFT);
      done     = (state_q == DONE);
      sum      = sum_q;
      carry    = carry_q;
      overflow = ovf_q;
   end

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub at WIDTH = 1, 8 and 32 with an arithmetic
// reference model.
module tb_serial_add_sub;

   logic        clk;
   logic        rst;
   logic [31:0] a_in, b_in;
   logic        cin_in, sub_in;
   logic        start1, start8, start32;

   logic        busy1, done1, carry1, ovf1;
   logic [0:0]  sum1;
   logic        busy8, done8, carry8, ovf8;
   logic [7:0]  sum8;
   logic        busy32, done32, carry32, ovf32;
   logic [31:0] sum32;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   serial_add_sub #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst(rst), .start(start1), .a(a_in[0:0]), .b(b_in[0:0]),
      .cin(cin_in), .sub(sub_in), .busy(busy1), .done(done1),
      .sum(sum1), .carry(carry1), .overflow(ovf1));

   serial_add_sub #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst(rst), .start(start8), .a(a_in[7:0]), .b(b_in[7:0]),
      .cin(cin_in), .sub(sub_in), .busy(busy8), .done(done8),
      .sum(sum8), .carry(carry8), .overflow(ovf8));

   serial_add_sub #(.WIDTH(32)) u_w32 (
      .clk(clk), .rst(rst), .start(start32), .a(a_in), .b(b_in),
      .cin(cin_in), .sub(sub_in), .busy(busy32), .done(done32),
      .sum(sum32), .carry(carry32), .overflow(ovf32));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: plain integer addition; overflow from the sign rule.
   function automatic logic [33:0] model(input int w, input logic [31:0] av,
                                         input logic [31:0] bv, input logic ci,
                                         input logic sb);
      logic [63:0] m, x, y, full;
      logic        c0, sa, sy, ss;
      m    = (64'd1 << w) - 64'd1;
      x    = {32'd0, av} & m;
      y    = (sb ? {32'd0, ~bv} : {32'd0, bv}) & m;
      c0   = sb ? 1'b1 : ci;
      full = x + y + {63'd0, c0};
      sa   = x[w-1];
      sy   = y[w-1];
      ss   = full[w-1];
      return {(sa == sy) && (ss != sa), full[w], full[31:0] & m[31:0]};
   endfunction

   function automatic logic [33:0] obs(input int w);
      case (w)
         1:       return {ovf1, carry1, 31'd0, sum1};
         8:       return {ovf8, carry8, 24'd0, sum8};
         default: return {ovf32, carry32, sum32};
      endcase
   endfunction

   function automatic logic busy_of(input int w);
      case (w)
         1:       return busy1;
         8:       return busy8;
         default: return busy32;
      endcase
   endfunction

   function automatic logic done_of(input int w);
      case (w)
         1:       return done1;
         8:       return done8;
         default: return done32;
      endcase
   endfunction

   task automatic set_start(input int w, input logic v);
      case (w)
         1:       start1  = v;
         8:       start8  = v;
         default: start32 = v;
      endcase
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Run one operation; inputs are scrambled right after acceptance.
   // bad counts busy/hold/pulse-width violations seen along the way.
   task automatic run_op(input int w, input logic [31:0] av, input logic [31:0] bv,
                         input logic ci, input logic sb, output logic [33:0] res,
                         output int lat, output int bad);
      logic [33:0] pre;
      @(negedge clk);
      a_in = av; b_in = bv; cin_in = ci; sub_in = sb;
      set_start(w, 1'b1);
      tick();
      set_start(w, 1'b0);
      a_in = $urandom; b_in = $urandom; cin_in = 1'($urandom); sub_in = 1'($urandom);
      pre = obs(w);
      lat = 0;
      bad = 0;
      while (done_of(w) !== 1'b1 && lat < 200) begin
         if (busy_of(w) !== 1'b1 || obs(w) !== pre) bad++;
         tick();
         lat++;
      end
      if (busy_of(w) !== 1'b0) bad++;
      res = obs(w);
      tick();
      if (done_of(w) !== 1'b0) bad++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start1 = 0; start8 = 0; start32 = 0;
      a_in = '0; b_in = '0; cin_in = 0; sub_in = 0;
      repeat (2) tick();
      n_vec++;
      if ({busy1, done1, obs(1)} !== 36'd0) begin
         n_err++; $display("FAIL reset_w1 got=%h want=0", {busy1, done1, obs(1)});
      end
      n_vec++;
      if ({busy8, done8, obs(8)} !== 36'd0) begin
         n_err++; $display("FAIL reset_w8 got=%h want=0", {busy8, done8, obs(8)});
      end
      n_vec++;
      if ({busy32, done32, obs(32)} !== 36'd0) begin
         n_err++; $display("FAIL reset_w32 got=%h want=0", {busy32, done32, obs(32)});
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_directed();
      logic [31:0] ta [5] = '{32'hFF, 32'h7F, 32'h0F, 32'h05, 32'h80};
      logic [31:0] tb [5] = '{32'h01, 32'h01, 32'h01, 32'h07, 32'h01};
      logic        tc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic        ts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      // {overflow, carry, sum} as stated for each case
      logic [33:0] te [5] = '{{2'b01, 32'h00}, {2'b10, 32'h80}, {2'b00, 32'h11},
                              {2'b00, 32'hFE}, {2'b11, 32'h7F}};
      logic [33:0] res;
      int          lat, bad;
      for (int i = 0; i < 5; i++) begin
         run_op(8, ta[i], tb[i], tc[i], ts[i], res, lat, bad);
         n_vec++;
         if (res !== te[i]) begin
            n_err++; $display("FAIL directed%0d result got=%h want=%h", i, res, te[i]);
         end
         n_vec++;
         if (lat !== 8) begin
            n_err++; $display("FAIL directed%0d latency got=%0d want=8", i, lat);
         end
         n_vec++;
         if (bad !== 0) begin
            n_err++; $display("FAIL directed%0d busy_hold got=%0d want=0", i, bad);
         end
      end
   endtask

   task automatic test_width1();
      logic [33:0] res;
      logic [1:0]  want;
      int          lat, bad;
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v    = 3'(i);
         want = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
         run_op(1, {31'd0, v[2]}, {31'd0, v[1]}, v[0], 1'b0, res, lat, bad);
         n_vec++;
         if ({res[32], res[0]} !== want || lat !== 1 || bad !== 0) begin
            n_err++;
            $display("FAIL width1_%0d got cs=%b lat=%0d bad=%0d want cs=%b lat=1 bad=0",
                     i, {res[32], res[0]}, lat, bad, want);
         end
      end
      run_op(1, 32'd1, 32'd0, 1'b0, 1'b1, res, lat, bad);
      n_vec++;
      if (res !== model(1, 32'd1, 32'd0, 1'b0, 1'b1)) begin
         n_err++; $display("FAIL width1_sub got=%h want=%h", res, model(1, 32'd1, 32'd0, 1'b0, 1'b1));
      end
   endtask

   task automatic test_restart_ignored();
      logic [33:0] res;
      int          ndone;
      res   = '0;
      ndone = 0;
      @(negedge clk);
      a_in = 32'h3C; b_in = 32'h21; cin_in = 1'b0; sub_in = 1'b0;
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick();
      start8 = 1'b1; a_in = 32'hFF; b_in = 32'hFF; sub_in = 1'b1; cin_in = 1'b1;
      tick();
      start8 = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done8 === 1'b1) begin
            ndone++;
            res = obs(8);
         end
         tick();
      end
      n_vec++;
      if (ndone !== 1) begin
         n_err++; $display("FAIL restart_done_count got=%0d want=1", ndone);
      end
      n_vec++;
      if (res !== {2'b00, 32'h5D}) begin
         n_err++; $display("FAIL restart_result got=%h want=%h", res, {2'b00, 32'h5D});
      end
   endtask

   task automatic test_reset_mid_shift();
      logic [33:0] res;
      int          ndone, lat, bad;
      ndone = 0;
      @(negedge clk);
      a_in = 32'h12; b_in = 32'h34; cin_in = 1'b1; sub_in = 1'b0;
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      n_vec++;
      if ({busy8, done8, obs(8)} !== 36'd0) begin
         n_err++; $display("FAIL rst_mid_outputs got=%h want=0", {busy8, done8, obs(8)});
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (done8 === 1'b1) ndone++;
         tick();
      end
      n_vec++;
      if (ndone !== 0) begin
         n_err++; $display("FAIL rst_mid_no_done got=%0d want=0", ndone);
      end
      run_op(8, 32'h12, 32'h34, 1'b0, 1'b0, res, lat, bad);
      n_vec++;
      if (res !== {2'b00, 32'h46} || lat !== 8) begin
         n_err++; $display("FAIL rst_mid_next got=%h lat=%0d want=%h lat=8", res, lat, {2'b00, 32'h46});
      end
   endtask

   // Back-to-back operations with start held high; inputs are scrambled
   // during SHIFT and the next operands applied once done is seen.
   task automatic test_random(input int w, input int nops);
      logic [31:0] ca, cb;
      logic        cc, cs;
      logic [33:0] want;
      int          t, prev;
      prev = 0;
      ca = $urandom; cb = $urandom; cc = 1'($urandom); cs = 1'($urandom);
      @(negedge clk);
      a_in = ca; b_in = cb; cin_in = cc; sub_in = cs;
      set_start(w, 1'b1);
      for (int i = 0; i < nops; i++) begin
         t = 0;
         while (busy_of(w) !== 1'b1 && t < 10) begin
            tick();
            t++;
         end
         a_in = $urandom; b_in = $urandom; cin_in = 1'($urandom); sub_in = 1'($urandom);
         t = 0;
         while (done_of(w) !== 1'b1 && t < 100) begin
            tick();
            t++;
         end
         want = model(w, ca, cb, cc, cs);
         n_vec++;
         if (done_of(w) !== 1'b1) begin
            n_err++; $display("FAIL rand_w%0d_timeout op=%0d got=no_done want=done", w, i);
            break;
         end
         if (obs(w) !== want) begin
            n_err++;
            $display("FAIL rand_w%0d op=%0d a=%h b=%h cin=%b sub=%b got=%h want=%h",
                     w, i, ca, cb, cc, cs, obs(w), want);
         end
         if (i > 0) begin
            n_vec++;
            if (cyc - prev !== w + 2) begin
               n_err++; $display("FAIL rand_w%0d_period op=%0d got=%0d want=%0d", w, i, cyc - prev, w + 2);
            end
         end
         prev = cyc;
         ca = $urandom; cb = $urandom; cc = 1'($urandom); cs = 1'($urandom);
         a_in = ca; b_in = cb; cin_in = cc; sub_in = cs;
      end
      set_start(w, 1'b0);
      repeat (w + 4) tick();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_width1();
      test_restart_ignored();
      test_reset_mid_shift();
      test_random(8, 1000);
      test_random(32, 1000);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
